// File: rtl/ram_responder.sv
// Word-organised RAM responding to the CPU bus, with boot-time byte-stream loader.
// Optional zero-fill sweep before boot is compiled in with `define RAM_CLEAR_EN.
module ram_responder #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        range_err_o,
  output logic        cpu_hold_o,
  input  logic        boot_i,
  input  logic        load_valid_i,
  input  logic [7:0]  load_byte_i,
  input  logic        load_last_i,
  output logic        load_ready_o
);

  localparam logic [1:0] ST_START = 2'd0;
`ifdef RAM_CLEAR_EN
  localparam logic [1:0] ST_CLEAR = 2'd1;
`endif
  localparam logic [1:0] ST_LOAD  = 2'd2;
  localparam logic [1:0] ST_READY = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = {ADDR_WIDTH{1'b1}};

  logic [31:0] mem [2**ADDR_WIDTH];

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] load_ptr_q, load_ptr_d;
  logic [1:0]            lane_q, lane_d;
  logic [31:0]           word_q, word_d;
  logic [31:0]           data_q, data_d;
  logic                  err_q, err_d;
`ifdef RAM_CLEAR_EN
  logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;
`endif

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [31:0]           mem_wdata;
  logic [31:0]           assembled;
  logic [ADDR_WIDTH-1:0] bus_idx;
  logic                  in_range;
  logic                  unused_addr_lsbs;

  assign bus_idx          = addr_i[ADDR_WIDTH+1:2];
  assign in_range         = (addr_i[31:ADDR_WIDTH+2] == '0);
  assign unused_addr_lsbs = ^addr_i[1:0];

  // Partial word with the incoming byte dropped into its little-endian lane.
  always_comb begin
    assembled = word_q;
    case (lane_q)
      2'd0:    assembled[7:0]   = load_byte_i;
      2'd1:    assembled[15:8]  = load_byte_i;
      2'd2:    assembled[23:16] = load_byte_i;
      default: assembled[31:24] = load_byte_i;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    load_ptr_d = load_ptr_q;
    lane_d     = lane_q;
    word_d     = word_q;
    data_d     = 32'h0;
    err_d      = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = '0;
    mem_wdata  = 32'h0;
`ifdef RAM_CLEAR_EN
    clr_ptr_d  = clr_ptr_q;
`endif
    case (state_q)
      ST_START: begin
`ifdef RAM_CLEAR_EN
        state_d   = ST_CLEAR;
        clr_ptr_d = '0;
`else
        state_d = boot_i ? ST_LOAD : ST_READY;
`endif
      end
`ifdef RAM_CLEAR_EN
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == LAST_IDX) begin
          state_d = boot_i ? ST_LOAD : ST_READY;
        end
      end
`endif
      ST_LOAD: begin
        if (load_valid_i) begin
          if (lane_q == 2'd3 || load_last_i) begin
            mem_we     = 1'b1;
            mem_waddr  = load_ptr_q;
            mem_wdata  = assembled;
            load_ptr_d = load_ptr_q + 1'b1;
            lane_d     = 2'd0;
            word_d     = 32'h0;
            // The final word of the array ends the load even without a last marker.
            if (load_last_i || load_ptr_q == LAST_IDX) begin
              state_d = ST_READY;
            end
          end else begin
            lane_d = lane_q + 2'd1;
            word_d = assembled;
          end
        end
      end
      ST_READY: begin
        if (in_range) begin
          if (we_i) begin
            mem_we    = 1'b1;
            mem_waddr = bus_idx;
            mem_wdata = data_i;
            data_d    = data_i;
          end else begin
            data_d = mem[bus_idx];
          end
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = ST_START;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_START;
      load_ptr_q <= '0;
      lane_q     <= 2'd0;
      word_q     <= 32'h0;
      data_q     <= 32'h0;
      err_q      <= 1'b0;
`ifdef RAM_CLEAR_EN
      clr_ptr_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      load_ptr_q <= load_ptr_d;
      lane_q     <= lane_d;
      word_q     <= word_d;
      data_q     <= data_d;
      err_q      <= err_d;
`ifdef RAM_CLEAR_EN
      clr_ptr_q  <= clr_ptr_d;
`endif
    end
  end

  assign data_o       = data_q;
  assign range_err_o  = err_q;
  assign cpu_hold_o   = (state_q != ST_READY);
  assign load_ready_o = (state_q == ST_LOAD);

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder (ADDR_WIDTH=4): boot load, bus R/W, range, overflow, reset mid-load.
// Expected boot latency and memory contents follow RAM_CLEAR_EN when it is defined.
module tb_ram_responder;

  localparam int AW    = 4;
  localparam int DEPTH = 2**AW;
`ifdef RAM_CLEAR_EN
  localparam int BOOT_CYCLES = 1 + DEPTH;
`else
  localparam int BOOT_CYCLES = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = 32'h0;
  logic [31:0] data_i = 32'h0;
  logic [31:0] data_o;
  logic        range_err_o;
  logic        cpu_hold_o;
  logic        boot_i = 1'b0;
  logic        load_valid_i = 1'b0;
  logic [7:0]  load_byte_i = 8'h0;
  logic        load_last_i = 1'b0;
  logic        load_ready_o;

  int compareCount = 0;
  int mismatchCount = 0;

  logic [31:0] expData[$];
  logic        expErr[$];
  logic [31:0] model [DEPTH];

  ram_responder #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .we_i(we_i), .addr_i(addr_i), .data_i(data_i),
    .data_o(data_o), .range_err_o(range_err_o), .cpu_hold_o(cpu_hold_o),
    .boot_i(boot_i), .load_valid_i(load_valid_i), .load_byte_i(load_byte_i),
    .load_last_i(load_last_i), .load_ready_o(load_ready_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compareCount++;
    if (got !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Bus access in READY; expectation queued at drive time, checked one edge later.
  task automatic applyStimulus(input string tag, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata);
    logic [31:0] ed;
    logic        ee;
    int          idx;
    @(negedge clk);
    we_i = we; addr_i = addr; data_i = wdata;
    idx = int'(addr[AW+1:2]);
    if (addr[31:AW+2] != '0) begin
      ed = 32'h0; ee = 1'b1;
    end else if (we) begin
      model[idx] = wdata; ed = wdata; ee = 1'b0;
    end else begin
      ed = model[idx]; ee = 1'b0;
    end
    expData.push_back(ed);
    expErr.push_back(ee);
    @(posedge clk); #1;
    we_i = 1'b0;
    checkOutput({tag, "_data"}, data_o, expData.pop_front());
    checkOutput({tag, "_err"}, {31'h0, range_err_o}, {31'h0, expErr.pop_front()});
  endtask

  task automatic sendByte(input logic [7:0] b, input logic last, output logic accepted);
    @(negedge clk);
    load_valid_i = 1'b1; load_byte_i = b; load_last_i = last;
    accepted = load_ready_o;
    @(posedge clk); #1;
  endtask

  task automatic stopLoad();
    @(negedge clk);
    load_valid_i = 1'b0; load_last_i = 1'b0;
  endtask

  task automatic restart(input logic boot);
    @(negedge clk);
    reset = 1'b0;
    boot_i = boot;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic waitLoadReady(output int cyc);
    cyc = 0;
    while (!load_ready_o && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic waitReady(output int cyc);
    cyc = 0;
    while (cpu_hold_o && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  initial begin
    int          cyc;
    int          acceptedCount;
    logic        acc;
    logic [31:0] w;

    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;

    #3;
    checkOutput("rst_data", data_o, 32'h0);
    checkOutput("rst_err", {31'h0, range_err_o}, 32'h0);
    checkOutput("rst_hold", {31'h0, cpu_hold_o}, 32'h1);
    checkOutput("rst_ready", {31'h0, load_ready_o}, 32'h0);

    boot_i = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    waitLoadReady(cyc);
    checkOutput("boot_to_load", cyc, BOOT_CYCLES);
    checkOutput("hold_in_load", {31'h0, cpu_hold_o}, 32'h1);

    acceptedCount = 0;
    for (int i = 1; i <= 5; i++) begin
      w[7:0] = 8'(i * 8'h11);
      sendByte(w[7:0], i == 5, acc);
      if (acc) acceptedCount++;
    end
    stopLoad();
    model[0] = 32'h44332211;
    model[1] = 32'h00000055;
    checkOutput("load_accepted", acceptedCount, 5);
    checkOutput("hold_after_load", {31'h0, cpu_hold_o}, 32'h0);
    checkOutput("ready_after_load", {31'h0, load_ready_o}, 32'h0);

    applyStimulus("rd_w0", 1'b0, 32'h0, 32'h0);
    applyStimulus("rd_w1", 1'b0, 32'h4, 32'h0);
`ifdef RAM_CLEAR_EN
    for (int a = 8; a <= 32'h3C; a += 4) applyStimulus("rd_clear", 1'b0, 32'(a), 32'h0);
`endif

    applyStimulus("wr_8", 1'b1, 32'h8, 32'hDEADBEEF);
    applyStimulus("rd_8", 1'b0, 32'h8, 32'h0);
    applyStimulus("wr_9", 1'b1, 32'h9, 32'h12345678);
    applyStimulus("rd_8_alias", 1'b0, 32'h8, 32'h0);
    applyStimulus("wr_oor", 1'b1, 32'h40, 32'h1);
    applyStimulus("rd_oor", 1'b0, 32'h40, 32'h0);
    applyStimulus("rd_oor_hi", 1'b0, 32'h8000_0000, 32'h0);
    applyStimulus("rd_w0_kept", 1'b0, 32'h0, 32'h0);
    applyStimulus("wr_top", 1'b1, 32'h3F, 32'hCAFEF00D);
    applyStimulus("rd_top", 1'b0, 32'h3C, 32'h0);

    // Reset in the middle of a word; the partial bytes must never land in memory.
    restart(1'b1);
    waitLoadReady(cyc);
    checkOutput("reload_wait", cyc, BOOT_CYCLES);
    sendByte(8'hAA, 1'b0, acc);
    sendByte(8'hBB, 1'b0, acc);
    @(negedge clk);
    reset = 1'b0;
    load_valid_i = 1'b0;
    boot_i = 1'b0;
    #1;
    checkOutput("midload_hold", {31'h0, cpu_hold_o}, 32'h1);
    checkOutput("midload_ready", {31'h0, load_ready_o}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
`ifdef RAM_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
`endif
    waitReady(cyc);
    checkOutput("noboot_ready", cyc, BOOT_CYCLES);
    applyStimulus("rd_w0_after_rst", 1'b0, 32'h0, 32'h0);
    applyStimulus("rd_8_after_rst", 1'b0, 32'h8, 32'h0);

    // Stream more bytes than the array holds, without a last marker.
    restart(1'b1);
    waitLoadReady(cyc);
    acceptedCount = 0;
    for (int i = 0; i < 4 * DEPTH + 6; i++) begin
      sendByte(8'(i), 1'b0, acc);
      if (acc) acceptedCount++;
    end
    stopLoad();
    for (int i = 0; i < DEPTH; i++) begin
      w = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
      model[i] = w;
    end
    checkOutput("ovf_accepted", acceptedCount, 4 * DEPTH);
    checkOutput("ovf_hold", {31'h0, cpu_hold_o}, 32'h0);
    checkOutput("ovf_ready", {31'h0, load_ready_o}, 32'h0);
    applyStimulus("ovf_w0", 1'b0, 32'h0, 32'h0);
    applyStimulus("ovf_w7", 1'b0, 32'h1C, 32'h0);
    applyStimulus("ovf_w15", 1'b0, 32'h3C, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
